pipe_hazard_scoreboard: RTL

Parametrised hazard and forwarding scoreboard for the MIPS pipeline, sitting beside the decode stage. It records every in-flight register write together with its producer latency. Each cycle it tells decode, per source operand, which later stage to forward from and whether the instruction in ID must stall. It generalises the fixed load-use check to arbitrary producer latencies (loads, multi-cycle MUL), and adds an optional LL/SC link-tracking state machine.

---
 rtl/pipe_hazard_pkg.sv | 27 ++
 rtl/pipe_hazard_scoreboard_if.sv | 40 ++++
 rtl/pipe_hazard_scoreboard_sb_entry.sv | 42 ++++
 rtl/pipe_hazard_scoreboard.sv | 120 ++++++++++++
 4 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared constants, link-state type and latency helper for the hazard scoreboard.
// Forward-select codes: FWD_REGFILE..FWD_WB. Latency codes: LAT_ALU, LAT_LOAD, LAT_MUL.
// No ports: compile this file before the interface, the entry and the top.
package pipe_hazard_pkg;

  // Forward-select encoding seen by decode (value = age of the producer).
  localparam int FWD_REGFILE = 0;
  localparam int FWD_EX      = 1;
  localparam int FWD_MEM     = 2;
  localparam int FWD_WB      = 3;

  // Producer latency in cycles after entering EX until the result is forwardable.
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LINKED = 1'b1
  } link_state_t;

  // Clamp a requested latency to the largest one the scoreboard tracks.
  function automatic int sat_lat(input int lat, input int max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode <-> scoreboard bundle: issue request, source lookups, instruction class, results.
// master = decode side (drives hold/issue/sources/class), slave = scoreboard (drives
// stall, fwd_rs_sel, fwd_rt_sel, atomic, sc_success). Parameters must match the top.
interface pipe_hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int LAT_W  = 2,
  parameter int AGE_W  = 2
);
  logic              hold;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [LAT_W-1:0]  issue_lat;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_used;
  logic              rt_used;
  logic              is_ll;
  logic              is_sc;
  logic              is_store;
  logic              stall;
  logic [AGE_W-1:0]  fwd_rs_sel;
  logic [AGE_W-1:0]  fwd_rt_sel;
  logic              atomic;
  logic              sc_success;

  modport master (
    output hold, issue_valid, issue_addr, issue_lat,
    output rs_addr, rt_addr, rs_used, rt_used,
    output is_ll, is_sc, is_store,
    input  stall, fwd_rs_sel, fwd_rt_sel, atomic, sc_success
  );

  modport slave (
    input  hold, issue_valid, issue_addr, issue_lat,
    input  rs_addr, rt_addr, rs_used, rt_used,
    input  is_ll, is_sc, is_store,
    output stall, fwd_rs_sel, fwd_rt_sel, atomic, sc_success
  );

endinterface

// File: rtl/pipe_hazard_scoreboard_sb_entry.sv
// One register's in-flight write tracker: age (pipeline position) and ready countdown.
// Ports: clk, rst_n, advance (pipeline moves), load/load_ready (new accept), age, ready.
// A load always wins over the normal advance; with advance low the entry is frozen.
module sb_entry
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH   = 3,
  parameter int MAX_LAT = 3,
  parameter int LAT_W   = $clog2(MAX_LAT + 1),
  parameter int AGE_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             load,
  input  logic [LAT_W-1:0] load_ready,
  output logic [AGE_W-1:0] age,
  output logic [LAT_W-1:0] ready
);

  logic [AGE_W-1:0] age_q;
  logic [LAT_W-1:0] ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q   <= '0;
      ready_q <= '0;
    end else if (load) begin
      // Newest producer replaces whatever was pending, including one retiring now.
      age_q   <= AGE_W'(1);
      ready_q <= load_ready;
    end else if (advance && (age_q != '0)) begin
      // After sitting in WB the value lives in the regfile only.
      age_q   <= (age_q == AGE_W'(DEPTH)) ? '0 : age_q + 1'b1;
      ready_q <= (ready_q == '0) ? '0 : ready_q - 1'b1;
    end
  end

  assign age   = age_q;
  assign ready = ready_q;

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding scoreboard beside decode: per-register producer tracking, operand
// forward selects, load/multi-cycle stall, optional LL/SC link (PIPE_HAZARD_ATOMIC_EN).
// Ports: clk, rst_n (async active-low), bus (slave modport). Lookups are combinational.
module pipe_hazard_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int DEPTH    = 3,
  parameter int MAX_LAT  = 3,
  parameter int LAT_W    = $clog2(MAX_LAT + 1),
  parameter int AGE_W    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipe_hazard_scoreboard_if.slave bus
);

  logic [AGE_W-1:0] age_arr [NUM_REGS];
  logic [LAT_W-1:0] rdy_arr [NUM_REGS];

  logic             stall_int;
  logic             accept;
  logic             advance;
  logic [LAT_W-1:0] lat_sat;

  logic             rs_live;
  logic             rt_live;
  logic             rs_wait;
  logic             rt_wait;
  logic [AGE_W-1:0] rs_sel;
  logic [AGE_W-1:0] rt_sel;

  assign advance = ~bus.hold;
  // Writes to $0 are discarded so a consumer of $0 never waits or forwards.
  assign accept  = bus.issue_valid & ~stall_int & ~bus.hold & (bus.issue_addr != '0);
  assign lat_sat = LAT_W'(sat_lat(int'(bus.issue_lat), MAX_LAT));

  // $0 has no tracker; its slot reads as permanently idle.
  assign age_arr[0] = '0;
  assign rdy_arr[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(
      .DEPTH   (DEPTH),
      .MAX_LAT (MAX_LAT),
      .LAT_W   (LAT_W),
      .AGE_W   (AGE_W)
    ) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .advance    (advance),
      .load       (accept && (bus.issue_addr == ADDR_W'(r))),
      .load_ready (lat_sat),
      .age        (age_arr[r]),
      .ready      (rdy_arr[r])
    );
  end

  // Lookup: the age of a pending producer is exactly the stage it sits in.
  always_comb begin
    rs_live = bus.rs_used && (bus.rs_addr != '0);
    rt_live = bus.rt_used && (bus.rt_addr != '0);
    rs_sel  = rs_live ? age_arr[bus.rs_addr] : '0;
    rt_sel  = rt_live ? age_arr[bus.rt_addr] : '0;
    rs_wait = rs_live && (age_arr[bus.rs_addr] != '0) && (rdy_arr[bus.rs_addr] != '0);
    rt_wait = rt_live && (age_arr[bus.rt_addr] != '0) && (rdy_arr[bus.rt_addr] != '0);
  end

  assign stall_int      = rs_wait | rt_wait;
  assign bus.stall      = stall_int;
  assign bus.fwd_rs_sel = rs_sel;
  assign bus.fwd_rt_sel = rt_sel;

`ifdef PIPE_HAZARD_ATOMIC_EN
  link_state_t link_state;
  logic        atomic_q;
  logic        link_step;

  // The link only moves when the ID instruction actually leaves decode.
  assign link_step = ~stall_int & ~bus.hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_state <= IDLE;
      atomic_q   <= 1'b0;
    end else if (link_step) begin
      case (link_state)
        IDLE: begin
          if (bus.is_ll) begin
            link_state <= LINKED;
            atomic_q   <= 1'b1;
          end
        end
        LINKED: begin
          // Any store (including the SC itself) breaks the reservation.
          if (bus.is_store || bus.is_sc) begin
            link_state <= IDLE;
            atomic_q   <= 1'b0;
          end
        end
        default: begin
          link_state <= IDLE;
          atomic_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.atomic     = atomic_q;
  assign bus.sc_success = bus.is_sc & (link_state == LINKED);
`else
  // Without link tracking every SC fails and the class inputs are don't-care.
  logic unused_link_inputs;
  assign unused_link_inputs = ^{bus.is_ll, bus.is_sc, bus.is_store};
  assign bus.atomic         = 1'b0;
  assign bus.sc_success     = 1'b0;
`endif

endmodule
